mem_responder: RTL and testbench
================================

# mem_responder

Multi-cycle memory responder for the data side of the CPU's memory interface. It accepts a single word-sized read or write request through a request/ready handshake, waits a fixed number of cycles, performs the access on an internal word array, and signals completion. The CPU pipeline stalls on it in place of a single-cycle synchronous memory. Its port semantics match the existing memory interface (`read_write` = 1 means read, 4-bit byte enable).

## Interface
- `DEPTH_LOG2`, default 10: log2 of the number of 32-bit words in the array.
- `LATENCY`, default 4: cycles from request acceptance to `ready`. Legal range is 1..255.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req` input 1: request valid; sampled only in IDLE.
- `read_write` input 1: 1 = read, 0 = write.
- `addr` input 32: byte address.
- `data_in` input 32: write data.
- `byte_enable` input 4: bit i enables write of `data_in[8i+7:8i]`.
- `ready` output 1: one-cycle completion pulse.
- `data_out` output 32: read data; valid when `ready`=1 and the access was a read.
- `error` output 1: asserted with `ready` when the request was misaligned.
- `busy` output 1: 1 whenever the state is not IDLE.

## Operation
- **States:** IDLE, WAIT, DONE. A down-counter `cnt` is 8 bits wide.
- **IDLE:**
  - If `req`=1 at the edge, latch `addr`, `data_in`, `byte_enable` and `read_write`.
  - Load `cnt` = LATENCY-1 and go to WAIT.
  - After acceptance the requester may change its inputs freely.
- **WAIT:**
  - If `cnt`≠0, decrement `cnt` each edge.
  - If `cnt`=0, perform the access at that edge and go to DONE.
- **DONE:** lasts exactly one cycle, with `ready`=1. Unconditionally go to IDLE. `req` is ignored in DONE.
- **Access:**
  - Word index = latched `addr[DEPTH_LOG2+1:2]`. Upper address bits are ignored, so addresses alias (wrap-around).
  - Read: `data_out` ← array word. The full word is returned regardless of `byte_enable`.
  - Write: update only the enabled bytes. `byte_enable`=0000 is a legal no-op write.
- **Misalignment:** if the latched `addr[1:0]`≠00, no array read or write happens. `error`=1 during DONE and `data_out` keeps its previous value.
- **`data_out` holding:** holds its value until the next successful read. Writes do not change it.
- **Back-to-back requests:** a requester that keeps `req` high after seeing `ready` issues a new request. That request is accepted at the first edge in IDLE, i.e. the edge after DONE.
- **Array contents:** initialised to zero at time 0 and not affected by `reset`.

## Timing
- **Reset values:** `ready`=0, `error`=0, `busy`=0, `data_out`=0, state IDLE, `cnt`=0. All take effect immediately on `reset` assertion, without waiting for a clock edge.
- **Reset during WAIT:** the pending access is abandoned and no write occurs. The first request after reset deasserts is sampled at the first edge with `reset` low.
- **Latency:** with the request accepted at edge t, the access happens at edge t+LATENCY. `ready`, `error` and `data_out` are valid in the cycle following edge t+LATENCY.
- **Throughput:** minimum `req`-to-`req` spacing is LATENCY+2 edges (accept, LATENCY−1 WAIT edges, access edge, DONE→IDLE edge). One request is outstanding at most.
- **`busy`:** rises in the cycle after the accept edge and falls in the cycle after DONE.
- **`ready` and `error`:** registered outputs, high for exactly one cycle per request.

## Test plan
- **Write then read, LATENCY=4:**
  - Write 0xDEADBEEF to addr 0x10 with `byte_enable`=1111. Expect `ready` in the cycle after edge t+4, with `error`=0.
  - Read addr 0x10. Expect `data_out`=0xDEADBEEF with `ready`.
- **Byte enables:**
  - Start with word 0x00000000 at 0x20.
  - Write 0xAABBCCDD with `byte_enable`=0101, then read. Expect 0x00BB00DD.
  - Then write with `byte_enable`=0000 and read again. Expect 0x00BB00DD unchanged.
- **Misaligned and wrap-around, DEPTH_LOG2=10:**
  - Write to 0x13. Expect `error`=1 with `ready`, and word 0x10 unchanged.
  - Write 0x12345678 to 0x1004, then read 0x0004. Expect 0x12345678 (aliasing).
- **Reset mid-operation:**
  - Issue a write of 0xFFFFFFFF to 0x40 and assert `reset` during WAIT, between edges. Expect `busy`=0 and `ready`=0 immediately.
  - After reset, read 0x40. Expect the prior value, not 0xFFFFFFFF.
- **`req` held continuously, LATENCY=1:**
  - Hold `req`=1 with a read of 0x0. Expect `ready` pulses every 3 cycles, each exactly one cycle wide.
  - Expect `req` to be ignored during DONE and `busy` low for exactly one cycle between requests.

Source files
------------

// File: rtl/mem_responder.sv
// Multi-cycle data-side memory responder.
// Accepts one request, waits LATENCY edges, accesses the array, pulses ready.
module mem_responder #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned LATENCY    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        read_write,
   input  logic [31:0] addr,
   input  logic [31:0] data_in,
   input  logic [3:0]  byte_enable,
   output logic        ready,
   output logic [31:0] data_out,
   output logic        error,
   output logic        busy
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [DEPTH_LOG2+1:0] addr_q;
   logic [31:0]           wdata_q;
   logic [3:0]            be_q;
   logic                  rd_q;
   logic                  ready_q, ready_d;
   logic                  error_q, error_d;
   logic [31:0]           dout_q, dout_d;
   logic                  latch_en;
   logic                  wr_en;
   logic [DEPTH_LOG2-1:0] idx;
   logic                  misaligned;

   // Array starts zeroed and is deliberately outside the reset domain.
   logic [31:0] mem_q [DEPTH] = '{default: '0};

   // Upper address bits only alias; they never select anything.
   logic unused_addr;
   assign unused_addr = ^addr[31:DEPTH_LOG2+2];

   assign idx        = addr_q[DEPTH_LOG2+1:2];
   assign misaligned = (addr_q[1:0] != 2'b00);

   assign ready    = ready_q;
   assign error    = error_q;
   assign data_out = dout_q;
   assign busy     = (state_q != S_IDLE);

   // Next-state, countdown and access decision.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ready_d  = 1'b0;
      error_d  = 1'b0;
      dout_d   = dout_q;
      latch_en = 1'b0;
      wr_en    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               latch_en = 1'b1;
               cnt_d    = CNT_INIT;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               state_d = S_DONE;
               ready_d = 1'b1;
               if (misaligned) begin
                  error_d = 1'b1;
               end else if (rd_q) begin
                  dout_d = mem_q[idx];
               end else begin
                  wr_en = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control state, request capture and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rd_q    <= 1'b0;
         ready_q <= 1'b0;
         error_q <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         error_q <= error_d;
         dout_q  <= dout_d;
         if (latch_en) begin
            addr_q  <= addr[DEPTH_LOG2+1:0];
            wdata_q <= data_in;
            be_q    <= byte_enable;
            rd_q    <= read_write;
         end
      end
   end

   // Byte-masked array write on the access edge.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
               mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: transaction-level model plus directed vectors.
// Instance a runs LATENCY=4, instance b runs LATENCY=1.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic        reqa = 1'b0, rwa = 1'b0;
   logic [31:0] addra = '0, dina = '0;
   logic [3:0]  bea = '0;
   logic        rdya, erra, busya;
   logic [31:0] douta;

   logic        reqb = 1'b0, rwb = 1'b0;
   logic [31:0] addrb = '0, dinb = '0;
   logic [3:0]  beb = '0;
   logic        rdyb, errb, busyb;
   logic [31:0] doutb;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) dut_a (
      .clk(clk), .reset(reset), .req(reqa), .read_write(rwa),
      .addr(addra), .data_in(dina), .byte_enable(bea),
      .ready(rdya), .data_out(douta), .error(erra), .busy(busya)
   );

   mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut_b (
      .clk(clk), .reset(reset), .req(reqb), .read_write(rwb),
      .addr(addrb), .data_in(dinb), .byte_enable(beb),
      .ready(rdyb), .data_out(doutb), .error(errb), .busy(busyb)
   );

   // ---------------- model ----------------
   logic [31:0] mm [2][1024];
   int          ecnt = 0;
   bit          pend [2] = '{0, 0};
   int          acc_e [2] = '{0, 0};
   int          done_e [2] = '{-10, -10};
   logic        m_rw [2];
   logic [31:0] m_addr [2];
   logic [31:0] m_din [2];
   logic [3:0]  m_be [2];
   logic        exp_rdy [2] = '{0, 0};
   logic        exp_err [2] = '{0, 0};
   logic        exp_busy [2] = '{0, 0};
   logic [31:0] exp_dout [2] = '{0, 0};

   initial begin
      for (int d = 0; d < 2; d++)
         for (int w = 0; w < 1024; w++)
            mm[d][w] = '0;
   end

   function automatic int lat(int d);
      return (d == 0) ? 4 : 1;
   endfunction

   task automatic step(int d, logic rq, logic rw, logic [31:0] ad,
                       logic [31:0] dn, logic [3:0] be);
      bit   idle_pre;
      int   w;
      idle_pre = !pend[d] && (ecnt != done_e[d] + 1);
      exp_rdy[d] = 1'b0;
      exp_err[d] = 1'b0;
      if (pend[d] && ecnt == acc_e[d] + lat(d)) begin
         pend[d]    = 1'b0;
         done_e[d]  = ecnt;
         exp_rdy[d] = 1'b1;
         if (m_addr[d][1:0] != 2'b00) begin
            exp_err[d] = 1'b1;
         end else begin
            w = int'(m_addr[d][11:2]);
            if (m_rw[d]) begin
               exp_dout[d] = mm[d][w];
            end else begin
               for (int i = 0; i < 4; i++)
                  if (m_be[d][i]) mm[d][w][8*i +: 8] = m_din[d][8*i +: 8];
            end
         end
      end
      if (idle_pre && rq) begin
         pend[d]   = 1'b1;
         acc_e[d]  = ecnt;
         m_rw[d]   = rw;
         m_addr[d] = ad;
         m_din[d]  = dn;
         m_be[d]   = be;
      end
      exp_busy[d] = pend[d] || exp_rdy[d];
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int d = 0; d < 2; d++) begin
            pend[d]     = 1'b0;
            done_e[d]   = -10;
            exp_rdy[d]  = 1'b0;
            exp_err[d]  = 1'b0;
            exp_busy[d] = 1'b0;
            exp_dout[d] = '0;
         end
      end else begin
         ecnt++;
         step(0, reqa, rwa, addra, dina, bea);
         step(1, reqb, rwb, addrb, dinb, beb);
      end
   end

   // ---------------- checking ----------------
   task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("a_ready", {31'd0, rdya}, {31'd0, exp_rdy[0]});
      chk("a_error", {31'd0, erra}, {31'd0, exp_err[0]});
      chk("a_busy", {31'd0, busya}, {31'd0, exp_busy[0]});
      chk("a_dout", douta, exp_dout[0]);
      chk("b_ready", {31'd0, rdyb}, {31'd0, exp_rdy[1]});
      chk("b_error", {31'd0, errb}, {31'd0, exp_err[1]});
      chk("b_busy", {31'd0, busyb}, {31'd0, exp_busy[1]});
      chk("b_dout", doutb, exp_dout[1]);
   end

   // ---------------- driving ----------------
   function automatic logic busy_of(int d);
      return (d == 0) ? busya : busyb;
   endfunction

   function automatic logic rdy_of(int d);
      return (d == 0) ? rdya : rdyb;
   endfunction

   task automatic drive(int d, logic rq, logic rw, logic [31:0] ad,
                        logic [31:0] dn, logic [3:0] be);
      if (d == 0) begin
         reqa = rq; rwa = rw; addra = ad; dina = dn; bea = be;
      end else begin
         reqb = rq; rwb = rw; addrb = ad; dinb = dn; beb = be;
      end
   endtask

   task automatic txn(int d, logic rw, logic [31:0] ad, logic [31:0] dn,
                      logic [3:0] be, output int seen,
                      output logic [31:0] dout, output logic err);
      int n;
      n = 0;
      while (busy_of(d) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         errors++;
         $display("FAIL idle_timeout: got busy expected idle");
      end
      drive(d, 1'b1, rw, ad, dn, be);
      @(posedge clk);
      @(negedge clk);
      drive(d, 1'b0, ~rw, ~ad, ~dn, ~be);
      n = 0;
      while (!rdy_of(d) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         errors++;
         $display("FAIL ready_timeout: got no ready expected ready");
      end
      seen = n;
      dout = (d == 0) ? douta : doutb;
      err  = (d == 0) ? erra : errb;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: got hang expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic [31:0] dv;
      logic        ev;

      #1;
      chk("rst_ready", {31'd0, rdya}, 32'd0);
      chk("rst_error", {31'd0, erra}, 32'd0);
      chk("rst_busy", {31'd0, busya}, 32'd0);
      chk("rst_dout", douta, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      txn(0, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, n, dv, ev);
      chk("wr10_latency", n, 32'd4);
      chk("wr10_error", {31'd0, ev}, 32'd0);
      txn(0, 1'b1, 32'h10, 32'h0, 4'h0, n, dv, ev);
      chk("rd10_dout", dv, 32'hDEADBEEF);
      chk("rd10_model", exp_dout[0], 32'hDEADBEEF);

      txn(0, 1'b0, 32'h20, 32'hAABBCCDD, 4'b0101, n, dv, ev);
      txn(0, 1'b1, 32'h20, 32'h0, 4'hF, n, dv, ev);
      chk("be0101_dout", dv, 32'h00BB00DD);
      txn(0, 1'b0, 32'h20, 32'h11223344, 4'b0000, n, dv, ev);
      chk("be0000_dout_held", dv, 32'h00BB00DD);
      txn(0, 1'b1, 32'h20, 32'h0, 4'h0, n, dv, ev);
      chk("be0000_dout", dv, 32'h00BB00DD);

      txn(0, 1'b0, 32'h13, 32'h55555555, 4'hF, n, dv, ev);
      chk("mis_error", {31'd0, ev}, 32'd1);
      chk("mis_dout_held", dv, 32'h00BB00DD);
      txn(0, 1'b1, 32'h10, 32'h0, 4'h0, n, dv, ev);
      chk("mis_word10", dv, 32'hDEADBEEF);
      txn(0, 1'b1, 32'h11, 32'h0, 4'h0, n, dv, ev);
      chk("mis_rd_error", {31'd0, ev}, 32'd1);
      chk("mis_rd_dout", dv, 32'hDEADBEEF);

      txn(0, 1'b0, 32'h1004, 32'h12345678, 4'hF, n, dv, ev);
      txn(0, 1'b1, 32'h0004, 32'h0, 4'h0, n, dv, ev);
      chk("alias_dout", dv, 32'h12345678);

      txn(0, 1'b0, 32'h40, 32'h0BADF00D, 4'hF, n, dv, ev);
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 32'h40, 32'hFFFFFFFF, 4'hF);
      @(posedge clk);
      #2;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(posedge clk);
      #2;
      chk("pre_rst_busy", {31'd0, busya}, 32'd1);
      reset = 1'b1;
      #1;
      chk("midrst_busy", {31'd0, busya}, 32'd0);
      chk("midrst_ready", {31'd0, rdya}, 32'd0);
      chk("midrst_dout", douta, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      txn(0, 1'b1, 32'h40, 32'h0, 4'h0, n, dv, ev);
      chk("midrst_word40", dv, 32'h0BADF00D);

      @(negedge clk);
      drive(1, 1'b1, 1'b1, 32'h0, 32'h0, 4'h0);
      n = 0;
      while (!rdyb && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("held_first_ready", {31'd0, rdyb}, 32'd1);
      for (int i = 0; i < 12; i++) begin
         chk("held_ready", {31'd0, rdyb}, (i % 3 == 0) ? 32'd1 : 32'd0);
         chk("held_busy", {31'd0, busyb}, (i % 3 != 1) ? 32'd1 : 32'd0);
         chk("held_dout", doutb, 32'd0);
         @(negedge clk);
      end
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
